// File: rtl/mips_mem_pkg.sv
// Shared encodings for the MIPS data-memory path: store size codes and the
// store-data sequencer state enum.
package mips_mem_pkg;

    localparam logic [1:0] SZ_WORD = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_BYTE = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_READ  = 3'd1,
        ST_WAIT  = 3'd2,
        ST_WRITE = 3'd3,
        ST_DONE  = 3'd4
    } wdata_state_t;

    // Reserved size code 2'b11 behaves as a word store.
    function automatic logic is_subword(input logic [1:0] size);
        return (size == SZ_HALF) || (size == SZ_BYTE);
    endfunction

endpackage

// File: rtl/wdata_merge.sv
// Combinational lane merge: inserts a byte or halfword of the store source
// into a previously read memory word; word stores pass the source through.
module wdata_merge
    import mips_mem_pkg::*;
(
    input  logic [31:0] i_src,
    input  logic [31:0] i_rdata,
    input  logic [1:0]  i_size,
    input  logic [1:0]  i_addr_lo,
    output logic [31:0] o_merged
);

    logic [7:0] w_lane [4];

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            assign w_lane[gi] = (i_addr_lo == 2'(gi)) ? i_src[7:0] : i_rdata[8*gi +: 8];
        end
    endgenerate

    // Halfword placement looks only at addr_lo[1]; addr_lo[0] is don't-care here.
    always_comb begin
        o_merged = i_src;
        case (i_size)
            SZ_BYTE: o_merged = {w_lane[3], w_lane[2], w_lane[1], w_lane[0]};
            SZ_HALF: o_merged = i_addr_lo[1] ? {i_src[15:0], i_rdata[15:0]}
                                             : {i_rdata[31:16], i_src[15:0]};
            default: o_merged = i_src;
        endcase
    end

endmodule

// File: rtl/mem_wdata_seq.sv
// Store-data sequencer: source select, word stores, and read-modify-write for
// sub-word stores. Optional alignment trap under macro WDATA_ALIGN_CHK_EN.
module mem_wdata_seq
    import mips_mem_pkg::*;
#(
    parameter int NUM_SRC = 2,
    parameter int RD_LAT  = 1
)
(
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic [NUM_SRC*32-1:0]      src_data,
    input  logic [$clog2(NUM_SRC)-1:0] src_sel,
    input  logic [1:0]                 size,
    input  logic [1:0]                 addr_lo,
    input  logic [31:0]                mem_rdata,
    output logic                       mem_re,
    output logic                       mem_we,
    output logic [31:0]                mem_wdata,
    output logic                       busy,
`ifdef WDATA_ALIGN_CHK_EN
    output logic                       align_err,
`endif
    output logic                       done
);

    localparam int SW = $clog2(NUM_SRC);
    localparam int CW = $clog2(RD_LAT + 1);
    localparam logic [CW-1:0] LAT_INIT = CW'(RD_LAT);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    wdata_state_t r_state;
    wdata_state_t w_state_next;

    logic [31:0]   r_src;
    logic [1:0]    r_size;
    logic [1:0]    r_addr_lo;
    logic [CW-1:0] r_cnt;
    logic [31:0]   w_sel_src;
    logic [31:0]   w_merged;
    logic          w_accept;
    logic          w_misaligned;

    logic          r_mem_re,    w_mem_re_next;
    logic          r_mem_we,    w_mem_we_next;
    logic [31:0]   r_mem_wdata, w_mem_wdata_next;
    logic          r_busy,      w_busy_next;
    logic          r_done,      w_done_next;

    // Out-of-range selects match no source and therefore yield zero.
    always_comb begin
        w_sel_src = 32'd0;
        for (int k = 0; k < NUM_SRC; k++) begin
            if (src_sel == k[SW-1:0]) begin
                w_sel_src = src_data[32*k +: 32];
            end
        end
    end

    assign w_accept = (r_state == ST_IDLE) && start;

`ifdef WDATA_ALIGN_CHK_EN
    assign w_misaligned = ((size == SZ_HALF) && addr_lo[0]) ||
                          (!is_subword(size) && (addr_lo != 2'b00));
`else
    assign w_misaligned = 1'b0;
`endif

    wdata_merge u_merge (
        .i_src     (r_src),
        .i_rdata   (mem_rdata),
        .i_size    (r_size),
        .i_addr_lo (r_addr_lo),
        .o_merged  (w_merged)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    if (w_misaligned)           w_state_next = ST_DONE;
                    else if (is_subword(size))  w_state_next = ST_READ;
                    else                        w_state_next = ST_WRITE;
                end
            end
            ST_READ:  w_state_next = ST_WAIT;
            ST_WAIT:  if (r_cnt == CNT_ONE) w_state_next = ST_WRITE;
            ST_WRITE: w_state_next = ST_DONE;
            ST_DONE:  w_state_next = ST_IDLE;
            default:  w_state_next = ST_IDLE;
        endcase
    end

    // Merged data is captured on the last WAIT edge, straight from mem_rdata.
    always_comb begin
        w_mem_re_next    = (w_state_next == ST_READ);
        w_mem_we_next    = (w_state_next == ST_WRITE);
        w_busy_next      = (w_state_next != ST_IDLE);
        w_done_next      = (w_state_next == ST_DONE);
        w_mem_wdata_next = r_mem_wdata;
        if (w_accept && (w_state_next == ST_WRITE)) begin
            w_mem_wdata_next = w_sel_src;
        end else if ((r_state == ST_WAIT) && (w_state_next == ST_WRITE)) begin
            w_mem_wdata_next = w_merged;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mem_re    <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_wdata <= 32'd0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_mem_re    <= w_mem_re_next;
            r_mem_we    <= w_mem_we_next;
            r_mem_wdata <= w_mem_wdata_next;
            r_busy      <= w_busy_next;
            r_done      <= w_done_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (r_state == ST_READ) begin
            r_cnt <= LAT_INIT;
        end else if ((r_state == ST_WAIT) && (r_cnt != '0)) begin
            r_cnt <= r_cnt - CNT_ONE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_src     <= 32'd0;
            r_size    <= SZ_WORD;
            r_addr_lo <= 2'b00;
        end else if (w_accept) begin
            r_src     <= w_sel_src;
            r_size    <= size;
            r_addr_lo <= addr_lo;
        end
    end

`ifdef WDATA_ALIGN_CHK_EN
    logic r_align_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_align_err <= 1'b0;
        end else begin
            r_align_err <= w_accept && w_misaligned;
        end
    end

    assign align_err = r_align_err;
`endif

    assign mem_re    = r_mem_re;
    assign mem_we    = r_mem_we;
    assign mem_wdata = r_mem_wdata;
    assign busy      = r_busy;
    assign done      = r_done;

endmodule

// File: tb/tb_mem_wdata_seq.sv
// Randomised self-checking bench for mem_wdata_seq (NUM_SRC=3, RD_LAT=3).
// Expected traces come from a cycle-numbered model of each store.
module tb_mem_wdata_seq;

    localparam int NUM_SRC = 3;
    localparam int RD_LAT  = 3;
    localparam int NREC    = RD_LAT + 5;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [95:0] src_data = '0;
    logic [1:0]  src_sel = '0;
    logic [1:0]  size = '0;
    logic [1:0]  addr_lo = '0;
    logic [31:0] mem_rdata = '0;
    logic        mem_re, mem_we, busy, done;
    logic [31:0] mem_wdata;
`ifdef WDATA_ALIGN_CHK_EN
    logic        align_err;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    // Observed per-cycle trace of the most recent store (index = cycle number).
    logic        obs_re    [NREC+1];
    logic        obs_we    [NREC+1];
    logic        obs_busy  [NREC+1];
    logic        obs_done  [NREC+1];
    logic        obs_align [NREC+1];
    logic [31:0] obs_wdata [NREC+1];

    mem_wdata_seq #(.NUM_SRC(NUM_SRC), .RD_LAT(RD_LAT)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .src_data  (src_data),
        .src_sel   (src_sel),
        .size      (size),
        .addr_lo   (addr_lo),
        .mem_rdata (mem_rdata),
        .mem_re    (mem_re),
        .mem_we    (mem_we),
        .mem_wdata (mem_wdata),
        .busy      (busy),
`ifdef WDATA_ALIGN_CHK_EN
        .align_err (align_err),
`endif
        .done      (done)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic logic ref_misaligned(input logic [1:0] sz, input logic [1:0] al);
`ifdef WDATA_ALIGN_CHK_EN
        if (sz == 2'b01) return al[0];
        if (sz == 2'b10) return 1'b0;
        return al != 2'b00;
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic ref_subword(input logic [1:0] sz);
        return (sz == 2'b01) || (sz == 2'b10);
    endfunction

    function automatic logic [31:0] ref_word(input logic [95:0] srcs, input logic [1:0] sel,
                                             input logic [1:0] sz, input logic [1:0] al,
                                             input logic [31:0] mword);
        logic [31:0] s;
        int sh;
        s = 32'd0;
        if (int'(sel) < NUM_SRC) s = srcs[32*sel +: 32];
        if (sz == 2'b10) begin
            sh = 8 * int'(al);
            return (mword & ~(32'hFF << sh)) | ((s & 32'hFF) << sh);
        end
        if (sz == 2'b01) begin
            sh = al[1] ? 16 : 0;
            return (mword & ~(32'hFFFF << sh)) | ((s & 32'hFFFF) << sh);
        end
        return s;
    endfunction

    // Cycle in which done is expected, counting the start-sampling cycle as 0.
    function automatic int ref_done_cycle(input logic [1:0] sz, input logic [1:0] al);
        if (ref_misaligned(sz, al)) return 1;
        if (ref_subword(sz)) return 3 + RD_LAT;
        return 2;
    endfunction

    // ---------------- stimulus ----------------
    // Drives one store and records outputs mid-cycle. mem_rdata carries mword
    // only in the cycle the read data is due; other cycles carry noise.
    // start stays high for cycles 1..hold_cycles to probe start-while-busy.
    task automatic run_store(input logic [95:0] srcs, input logic [1:0] sel,
                             input logic [1:0] sz, input logic [1:0] al,
                             input logic [31:0] mword, input int hold_cycles);
        @(negedge clk);
        obs_re[0] = mem_re;     obs_we[0] = mem_we;     obs_busy[0] = busy;
        obs_done[0] = done;     obs_wdata[0] = mem_wdata;
        start = 1'b1; src_data = srcs; src_sel = sel; size = sz; addr_lo = al;
        mem_rdata = $urandom();
        @(posedge clk);
        for (int c = 1; c <= NREC; c++) begin
            #1;
            start     = (c <= hold_cycles);
            src_data  = {$urandom(), $urandom(), $urandom()};
            src_sel   = 2'($urandom());
            size      = 2'($urandom());
            addr_lo   = 2'($urandom());
            mem_rdata = (c == 1 + RD_LAT) ? mword : $urandom();
            @(negedge clk);
            obs_re[c] = mem_re;     obs_we[c] = mem_we;     obs_busy[c] = busy;
            obs_done[c] = done;     obs_wdata[c] = mem_wdata;
`ifdef WDATA_ALIGN_CHK_EN
            obs_align[c] = align_err;
`else
            obs_align[c] = 1'b0;
`endif
            @(posedge clk);
        end
        #1 start = 1'b0;
        $display("store sel=%0d size=%0d addr_lo=%0d mword=%08h -> wdata=%08h",
                 sel, sz, al, mword, mem_wdata);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if ({mem_re, mem_we, busy, done} !== 4'b0000 || mem_wdata !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_state: got re/we/busy/done=%b wdata=%08h, want 0000 wdata=00000000",
                     {mem_re, mem_we, busy, done}, mem_wdata);
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        $display("reset released");
    endtask

    task automatic test_word_store();
        int re_cnt;
        run_store({32'h0, 32'hDEADBEEF, 32'h12345678}, 2'd1, 2'b00, 2'b00, 32'h55AA55AA, 0);
        n_checks++;
        if (obs_we[1] !== 1'b1 || obs_wdata[1] !== 32'hDEADBEEF) begin
            n_fail++;
            $display("FAIL word_write: got we=%b wdata=%08h, want we=1 wdata=deadbeef", obs_we[1], obs_wdata[1]);
        end
        n_checks++;
        if (obs_done[2] !== 1'b1 || obs_done[1] !== 1'b0 || obs_done[3] !== 1'b0) begin
            n_fail++;
            $display("FAIL word_done: got done c1..3=%b%b%b, want 010", obs_done[1], obs_done[2], obs_done[3]);
        end
        re_cnt = 0;
        for (int c = 0; c <= NREC; c++) if (obs_re[c] === 1'b1) re_cnt++;
        n_checks++;
        if (re_cnt != 0) begin
            n_fail++;
            $display("FAIL word_no_read: got %0d re cycles, want 0", re_cnt);
        end
    endtask

    task automatic test_byte_store();
        run_store({32'h0, 32'hFFFFFFFF, 32'h000000AB}, 2'd0, 2'b10, 2'd2, 32'h11223344, 0);
        n_checks++;
        if (obs_re[1] !== 1'b1 || obs_we[1] !== 1'b0) begin
            n_fail++;
            $display("FAIL byte_read: got re=%b we=%b in cycle 1, want re=1 we=0", obs_re[1], obs_we[1]);
        end
        n_checks++;
        if (obs_we[2 + RD_LAT] !== 1'b1 || obs_wdata[2 + RD_LAT] !== 32'h11AB3344) begin
            n_fail++;
            $display("FAIL byte_write: got we=%b wdata=%08h, want we=1 wdata=11ab3344",
                     obs_we[2 + RD_LAT], obs_wdata[2 + RD_LAT]);
        end
        n_checks++;
        if (obs_done[3 + RD_LAT] !== 1'b1 || obs_we[1 + RD_LAT] !== 1'b0) begin
            n_fail++;
            $display("FAIL byte_timing: got done@%0d=%b we@%0d=%b, want 1 and 0",
                     3 + RD_LAT, obs_done[3 + RD_LAT], 1 + RD_LAT, obs_we[1 + RD_LAT]);
        end
    endtask

    task automatic test_half_store();
        run_store({32'h0, 32'h0, 32'h0000CAFE}, 2'd0, 2'b01, 2'd2, 32'h11223344, 0);
        n_checks++;
        if (obs_we[2 + RD_LAT] !== 1'b1 || obs_wdata[2 + RD_LAT] !== 32'hCAFE3344) begin
            n_fail++;
            $display("FAIL half_write: got we=%b wdata=%08h, want we=1 wdata=cafe3344",
                     obs_we[2 + RD_LAT], obs_wdata[2 + RD_LAT]);
        end
    endtask

    task automatic test_invalid_src_and_busy();
        int n_done, n_we, n_re;
        run_store({32'hAAAA5555, 32'h12121212, 32'h34343434}, 2'd3, 2'b00, 2'b00, 32'h0, 0);
        n_checks++;
        if (obs_we[1] !== 1'b1 || obs_wdata[1] !== 32'd0) begin
            n_fail++;
            $display("FAIL invalid_src: got we=%b wdata=%08h, want we=1 wdata=00000000", obs_we[1], obs_wdata[1]);
        end
        // start held high from READ through WRITE must not spawn a second store.
        run_store({32'h0, 32'h0, 32'h000000C3}, 2'd0, 2'b10, 2'd1, 32'hA1B2C3D4, RD_LAT + 2);
        n_done = 0; n_we = 0; n_re = 0;
        for (int c = 1; c <= NREC; c++) begin
            if (obs_done[c] === 1'b1) n_done++;
            if (obs_we[c] === 1'b1) n_we++;
            if (obs_re[c] === 1'b1) n_re++;
        end
        n_checks++;
        if (n_done != 1 || n_we != 1 || n_re != 1) begin
            n_fail++;
            $display("FAIL busy_start: got done=%0d we=%0d re=%0d, want 1 1 1", n_done, n_we, n_re);
        end
        n_checks++;
        if (obs_wdata[2 + RD_LAT] !== 32'hA1B2C3D4 - 32'h0000C300 + 32'h0000C300 - 32'h0000C300 + 32'h0000C300) begin
            n_fail++;
            $display("FAIL busy_start_data: got %08h, want a1b2c3d4", obs_wdata[2 + RD_LAT]);
        end
    endtask

    task automatic test_reset_mid_store();
        int bad;
        @(negedge clk);
        start = 1'b1; src_data = {64'h0, 32'h0000005A}; src_sel = 2'd0;
        size = 2'b10; addr_lo = 2'd3; mem_rdata = 32'h0;
        @(posedge clk);
        #1 start = 1'b0;
        @(posedge clk);                   // now in cycle 2 (WAIT)
        #3 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({mem_re, mem_we, busy, done} !== 4'b0000 || mem_wdata !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_mid: got re/we/busy/done=%b wdata=%08h, want 0000 wdata=00000000",
                     {mem_re, mem_we, busy, done}, mem_wdata);
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        bad = 0;
        for (int c = 0; c < NREC; c++) begin
            @(negedge clk);
            if (mem_we !== 1'b0 || busy !== 1'b0 || done !== 1'b0) bad++;
        end
        n_checks++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL reset_abandon: got %0d cycles with activity after release, want 0", bad);
        end
        $display("reset mid-store, then idle for %0d cycles", NREC);
        run_store({32'h0, 32'h0, 32'h0000005A}, 2'd0, 2'b10, 2'd3, 32'h01020304, 0);
        n_checks++;
        if (obs_we[2 + RD_LAT] !== 1'b1 || obs_wdata[2 + RD_LAT] !== 32'h5A020304 || obs_done[3 + RD_LAT] !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_recover: got we=%b wdata=%08h done=%b, want 1 5a020304 1",
                     obs_we[2 + RD_LAT], obs_wdata[2 + RD_LAT], obs_done[3 + RD_LAT]);
        end
    endtask

    task automatic test_align();
        int n_strobe;
        run_store({32'h0, 32'h0, 32'h0000BEEF}, 2'd0, 2'b01, 2'd1, 32'h11223344, 0);
        n_strobe = 0;
        for (int c = 1; c <= NREC; c++) if (obs_re[c] === 1'b1 || obs_we[c] === 1'b1) n_strobe++;
`ifdef WDATA_ALIGN_CHK_EN
        n_checks++;
        if (obs_align[1] !== 1'b1 || obs_done[1] !== 1'b1 || obs_align[2] !== 1'b0 || n_strobe != 0) begin
            n_fail++;
            $display("FAIL align_trap: got align=%b done=%b align2=%b strobes=%0d, want 1 1 0 0",
                     obs_align[1], obs_done[1], obs_align[2], n_strobe);
        end
`else
        n_checks++;
        if (obs_we[2 + RD_LAT] !== 1'b1 || obs_wdata[2 + RD_LAT] !== 32'h1122BEEF || n_strobe != 2) begin
            n_fail++;
            $display("FAIL align_off: got we=%b wdata=%08h strobes=%0d, want 1 1122beef 2",
                     obs_we[2 + RD_LAT], obs_wdata[2 + RD_LAT], n_strobe);
        end
`endif
    endtask

    task automatic test_random();
        logic [95:0] srcs;
        logic [1:0]  sel, sz, al;
        logic [31:0] mword, exp_word, exp_hold;
        logic        have_hold, mis, sub;
        logic [3:0]  exp_vec, got_vec;
        int          d;
        have_hold = 1'b0;
        exp_hold  = 32'd0;
        for (int t = 0; t < 24; t++) begin
            srcs  = {$urandom(), $urandom(), $urandom()};
            sel   = 2'($urandom_range(0, 3));
            sz    = 2'($urandom_range(0, 3));
            al    = 2'($urandom_range(0, 3));
            mword = $urandom();
            run_store(srcs, sel, sz, al, mword, 0);
            mis      = ref_misaligned(sz, al);
            sub      = ref_subword(sz);
            d        = ref_done_cycle(sz, al);
            exp_word = ref_word(srcs, sel, sz, al, mword);
            n_checks++;
            if (obs_busy[0] !== 1'b0 || (have_hold && obs_wdata[0] !== exp_hold)) begin
                n_fail++;
                $display("FAIL rnd%0d_idle: got busy=%b wdata=%08h, want busy=0 wdata=%08h",
                         t, obs_busy[0], obs_wdata[0], exp_hold);
            end
            for (int c = 1; c <= NREC; c++) begin
                exp_vec = {c <= d, c == d, sub && !mis && c == 1, !mis && c == d - 1};
                got_vec = {obs_busy[c], obs_done[c], obs_re[c], obs_we[c]};
                n_checks++;
                if (got_vec !== exp_vec || obs_align[c] !== (mis && c == 1)) begin
                    n_fail++;
                    $display("FAIL rnd%0d_c%0d busy/done/re/we/align: got %b%b, want %b%b",
                             t, c, got_vec, obs_align[c], exp_vec, mis && c == 1);
                end
                if (!mis && c >= d - 1) begin
                    n_checks++;
                    if (obs_wdata[c] !== exp_word) begin
                        n_fail++;
                        $display("FAIL rnd%0d_c%0d wdata: got %08h, want %08h", t, c, obs_wdata[c], exp_word);
                    end
                end
            end
            if (!mis) begin
                exp_hold  = exp_word;
                have_hold = 1'b1;
            end
        end
    endtask

    initial begin
        test_reset();
        test_word_store();
        test_byte_store();
        test_half_store();
        test_invalid_src_and_busy();
        test_reset_mid_store();
        test_align();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
